// File: rtl/cpu6_mem_subsys.sv
// cpu6_mem_subsys: one word-addressed single-port RAM shared by a fetch port and a data port
// through a round-robin arbiter. Define CPU6_MEM_ERR_EN to add if_err/d_err address checks.
module cpu6_mem_subsys #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [XLEN-1:0]   if_addr,
   output logic              if_ack,
   output logic [XLEN-1:0]   if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [XLEN/8-1:0] d_be,
   input  logic [XLEN-1:0]   d_addr,
   input  logic [XLEN-1:0]   d_wdata,
   output logic              d_ack,
   output logic [XLEN-1:0]   d_rdata
`ifdef CPU6_MEM_ERR_EN
   ,
   output logic              if_err,
   output logic              d_err
`endif
);
   localparam int unsigned NB  = XLEN / 8;
   localparam int unsigned OFS = $clog2(NB);
   localparam int unsigned AW  = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ACK} state_t;
   typedef enum logic {P_FETCH, P_DATA} port_t;

   state_t          r_state;
   port_t           r_port;
   port_t           r_last_grant;
   logic [2:0]      r_cnt;
   logic [XLEN-1:0] r_addr;
   logic [XLEN-1:0] r_wdata;
   logic            r_we;
   logic [NB-1:0]   r_be;
   logic [XLEN-1:0] r_mem [DEPTH_WORDS];

   logic [AW-1:0]   w_idx;
   logic            w_err;
   logic            w_grant_d;
   logic            w_access;
   logic            w_do_write;
   logic [XLEN-1:0] w_rd;

   assign w_idx = r_addr[OFS +: AW];

`ifdef CPU6_MEM_ERR_EN
   assign w_err = ((r_addr & XLEN'(NB - 1)) != '0) || ((r_addr >> (OFS + AW)) != '0);
`else
   logic w_unused;
   assign w_err    = 1'b0;
   assign w_unused = ^r_addr;
`endif

   // On a tie the port that did not win last time is granted
   assign w_grant_d  = d_req && (!if_req || (r_last_grant == P_FETCH));
   assign w_access   = (r_state == S_BUSY) && (r_cnt == '0) && !reset;
   assign w_do_write = w_access && r_we && !w_err;
   assign w_rd       = w_err ? '0 : r_mem[w_idx];

   always_ff @(posedge clk) begin
      if (w_do_write) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (r_be[i]) r_mem[w_idx][i*8 +: 8] <= r_wdata[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_port       <= P_FETCH;
         r_last_grant <= P_FETCH;
         r_cnt        <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_we         <= 1'b0;
         r_be         <= '0;
         if_ack       <= 1'b0;
         d_ack        <= 1'b0;
         if_rdata     <= '0;
         d_rdata      <= '0;
`ifdef CPU6_MEM_ERR_EN
         if_err       <= 1'b0;
         d_err        <= 1'b0;
`endif
      end else begin
         if_ack <= 1'b0;
         d_ack  <= 1'b0;
`ifdef CPU6_MEM_ERR_EN
         if_err <= 1'b0;
         d_err  <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (if_req || d_req) begin
                  r_port       <= w_grant_d ? P_DATA : P_FETCH;
                  r_last_grant <= w_grant_d ? P_DATA : P_FETCH;
                  r_addr       <= w_grant_d ? d_addr : if_addr;
                  r_we         <= w_grant_d && d_we;
                  r_be         <= d_be;
                  r_wdata      <= d_wdata;
                  r_cnt        <= 3'(WAIT_CYCLES);
                  r_state      <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 3'd1;
               end else begin
                  if (r_port == P_FETCH) begin
                     if_ack   <= 1'b1;
                     if_rdata <= w_rd;
`ifdef CPU6_MEM_ERR_EN
                     if_err   <= w_err;
`endif
                  end else begin
                     d_ack   <= 1'b1;
                     d_rdata <= r_we ? '0 : w_rd;
`ifdef CPU6_MEM_ERR_EN
                     d_err   <= w_err;
`endif
                  end
                  r_state <= S_ACK;
               end
            end
            S_ACK:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cpu6_mem_subsys.sv
// Self-checking bench for cpu6_mem_subsys: vector table, randomized traffic against a word-array
// model, contention, wait-state latency and reset-abort sequences.
module tb_cpu6_mem_subsys;
   localparam int unsigned DEPTH = 256;
   localparam int unsigned W     = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [3:0]  d_be;
   logic        if_ack, d_ack, if_err, d_err;
   logic [31:0] if_rdata, d_rdata;

   logic        a_reset, a_if_req, a_d_req, a_d_we;
   logic [31:0] a_if_addr, a_d_addr, a_d_wdata;
   logic [3:0]  a_d_be;
   logic        a0_if_ack, a0_d_ack, a7_if_ack, a7_d_ack;
   logic [31:0] a0_if_rdata, a0_d_rdata, a7_if_rdata, a7_d_rdata;

`ifdef CPU6_MEM_ERR_EN
   localparam bit ERR_EN = 1'b1;
   logic a0_if_err, a0_d_err, a7_if_err, a7_d_err;
`else
   localparam bit ERR_EN = 1'b0;
   assign if_err = 1'b0;
   assign d_err  = 1'b0;
`endif

   cpu6_mem_subsys #(.XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata)
`ifdef CPU6_MEM_ERR_EN
      , .if_err(if_err), .d_err(d_err)
`endif
   );

   cpu6_mem_subsys #(.XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(a_reset),
      .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a0_if_ack), .if_rdata(a0_if_rdata),
      .d_req(a_d_req), .d_we(a_d_we), .d_be(a_d_be), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
      .d_ack(a0_d_ack), .d_rdata(a0_d_rdata)
`ifdef CPU6_MEM_ERR_EN
      , .if_err(a0_if_err), .d_err(a0_d_err)
`endif
   );

   cpu6_mem_subsys #(.XLEN(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(7)) dut7 (
      .clk(clk), .reset(a_reset),
      .if_req(a_if_req), .if_addr(a_if_addr), .if_ack(a7_if_ack), .if_rdata(a7_if_rdata),
      .d_req(a_d_req), .d_we(a_d_we), .d_be(a_d_be), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
      .d_ack(a7_d_ack), .d_rdata(a7_d_rdata)
`ifdef CPU6_MEM_ERR_EN
      , .if_err(a7_if_err), .d_err(a7_d_err)
`endif
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: flat word array, index = word address modulo depth
   logic [31:0] m_mem [DEPTH];

   function automatic bit m_err(input logic [31:0] a);
      return ERR_EN && ((a % 4) != 0 || (a / 4) >= DEPTH);
   endfunction

   task automatic m_apply(input bit we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rd, output bit er);
      int unsigned ix;
      ix = (addr / 4) % DEPTH;
      er = m_err(addr);
      rd = '0;
      if (!er) begin
         if (we) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) m_mem[ix][b*8 +: 8] = wdata[b*8 +: 8];
         end else begin
            rd = m_mem[ix];
         end
      end
   endtask

   task automatic txn(input bit fetch, input bit we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err, output int lat);
      bit clash;
      clash = 1'b0;
      lat   = -1;
      rdata = '0;
      err   = 1'b0;
      if (fetch) begin
         if_req = 1'b1; if_addr = addr;
      end else begin
         d_req = 1'b1; d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
      end
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (fetch ? d_ack : if_ack) clash = 1'b1;
         if (fetch ? if_ack : d_ack) begin
            lat   = n;
            rdata = fetch ? if_rdata : d_rdata;
            err   = fetch ? if_err : d_err;
            break;
         end
      end
      if_req = 1'b0;
      d_req  = 1'b0;
      @(posedge clk); #1;
      chk("ack_pulse", {30'd0, if_ack, d_ack}, 32'd0);
      chk("ack_excl", {31'd0, clash}, 32'd0);
   endtask

   typedef struct {
      bit          fetch;
      bit          we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_err;
   } vec_t;

   vec_t        tbl [17];
   logic [31:0] last_if;
   logic [31:0] rd, mrd;
   logic        er;
   bit          mer;
   int          lat;

   task automatic run_one(input bit fetch, input bit we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input bit exp_er, input string tag);
      txn(fetch, we, be, addr, wdata, rd, er, lat);
      chk({tag, "_lat"}, 32'(lat), 32'(W + 2));
      chk({tag, "_rdata"}, rd, exp_rd);
`ifdef CPU6_MEM_ERR_EN
      chk({tag, "_err"}, {31'd0, er}, {31'd0, exp_er});
`endif
      if (fetch) last_if = exp_rd;
      else chk({tag, "_if_hold"}, if_rdata, last_if);
   endtask

   initial begin
      reset = 1'b1; if_req = 0; d_req = 0; d_we = 0; d_be = '0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      a_reset = 1'b1; a_if_req = 0; a_d_req = 0; a_d_we = 0; a_d_be = '0;
      a_if_addr = '0; a_d_addr = '0; a_d_wdata = '0;
      last_if = '0;

      tbl[0]  = '{0, 1, 4'hF, 32'h10,  32'hDEADBEEF, 32'h0, 0};
      tbl[1]  = '{0, 0, 4'h0, 32'h10,  32'h0, 32'hDEADBEEF, 0};
      tbl[2]  = '{0, 1, 4'h1, 32'h10,  32'h000000AA, 32'h0, 0};
      tbl[3]  = '{0, 0, 4'h0, 32'h10,  32'h0, 32'hDEADBEAA, 0};
      tbl[4]  = '{1, 0, 4'h0, 32'h10,  32'h0, 32'hDEADBEAA, 0};
      tbl[5]  = '{0, 1, 4'hF, 32'h14,  32'hCAFEF00D, 32'h0, 0};
      tbl[6]  = '{0, 1, 4'h0, 32'h14,  32'h12345678, 32'h0, 0};
      tbl[7]  = '{0, 0, 4'h0, 32'h14,  32'h0, 32'hCAFEF00D, 0};
      tbl[8]  = '{0, 1, 4'hF, 32'h0,   32'h55667788, 32'h0, 0};
      tbl[9]  = '{0, 1, 4'hF, 32'h400, 32'h11223344, 32'h0, ERR_EN};
      tbl[10] = '{0, 0, 4'h0, 32'h0,   32'h0, ERR_EN ? 32'h55667788 : 32'h11223344, 0};
      tbl[11] = '{0, 0, 4'h0, 32'h400, 32'h0, ERR_EN ? 32'h0 : 32'h11223344, ERR_EN};
      tbl[12] = '{1, 0, 4'h0, 32'h11,  32'h0, ERR_EN ? 32'h0 : 32'hDEADBEAA, ERR_EN};
      tbl[13] = '{0, 1, 4'h6, 32'h14,  32'h00ABCD00, 32'h0, 0};
      tbl[14] = '{0, 0, 4'h0, 32'h14,  32'h0, 32'hCAABCD0D, 0};
      tbl[15] = '{0, 1, 4'hF, 32'h3FC, 32'hFFFF0000, 32'h0, 0};
      tbl[16] = '{1, 0, 4'h0, 32'h3FC, 32'h0, 32'hFFFF0000, 0};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_if_ack", {31'd0, if_ack}, 32'd0);
      chk("rst_d_ack", {31'd0, d_ack}, 32'd0);
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
`ifdef CPU6_MEM_ERR_EN
      chk("rst_err", {30'd0, if_err, d_err}, 32'd0);
`endif
      reset = 1'b0;

      for (int i = 0; i < 17; i++) begin
         m_apply(tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, mrd, mer);
         run_one(tbl[i].fetch, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata,
                 tbl[i].exp_rdata, tbl[i].exp_err, $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 16; i++) begin
         logic [31:0] wd;
         wd = $urandom;
         m_apply(1'b1, 4'hF, 32'(i * 4), wd, mrd, mer);
         run_one(1'b0, 1'b1, 4'hF, 32'(i * 4), wd, mrd, mer, "init");
      end
      for (int i = 0; i < 60; i++) begin
         bit          f, w;
         logic [3:0]  be;
         logic [31:0] a, wd;
         f  = 1'($urandom_range(0, 1));
         w  = f ? 1'b0 : 1'($urandom_range(0, 1));
         be = 4'($urandom_range(0, 15));
         wd = $urandom;
         a  = 32'($urandom_range(0, 15) * 4);
         if ($urandom_range(0, 3) == 0) a = a + 32'h400 * $urandom_range(1, 3);
         if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
         m_apply(w, be, a, wd, mrd, mer);
         run_one(f, w, be, a, wd, mrd, mer, "rand");
      end

      // Contention: both ports requesting from reset release
      begin
         int   nacks, prev;
         logic [31:0] exp_f, exp_d;
         exp_f = m_mem[4];
         exp_d = m_mem[5];
         reset = 1'b1;
         @(posedge clk); #1;
         chk("cont_rst_rdata", d_rdata, 32'd0);
         if_req = 1'b1; if_addr = 32'h10;
         d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
         reset = 1'b0;
         nacks = 0;
         prev  = 0;
         for (int n = 1; n <= 40 && nacks < 4; n++) begin
            @(posedge clk); #1;
            if (if_ack && d_ack) chk("cont_both", 32'd1, 32'd0);
            if (if_ack || d_ack) begin
               chk($sformatf("cont_order%0d", nacks), {31'd0, d_ack}, {31'd0, (nacks % 2) == 0});
               chk($sformatf("cont_time%0d", nacks), 32'(n - prev),
                   (nacks == 0) ? 32'(W + 2) : 32'(W + 3));
               if (d_ack) chk("cont_d_rdata", d_rdata, exp_d);
               else       chk("cont_if_rdata", if_rdata, exp_f);
               prev = n;
               nacks++;
            end
         end
         chk("cont_count", 32'(nacks), 32'd4);
         if_req = 1'b0; d_req = 1'b0;
         repeat (2) @(posedge clk);
         #1;
      end

      // Wait-state extremes: 0 and 7 extra cycles
      begin
         int l0, l7;
         l0 = -1; l7 = -1;
         @(posedge clk); #1;
         a_reset = 1'b0;
         a_if_req = 1'b1; a_if_addr = 32'h0;
         for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (a0_if_ack && l0 < 0) l0 = n;
            if (a7_if_ack && l7 < 0) l7 = n;
         end
         a_if_req = 1'b0;
         chk("lat_w0", 32'(l0), 32'd2);
         chk("lat_w7", 32'(l7), 32'd9);
         a_reset = 1'b1;
         @(posedge clk); #1;
         a_reset = 1'b0;
      end

      // Reset during BUSY aborts a pending write
      begin
         bit seen, ack_after;
         seen = 1'b0;
         a_d_req = 1'b1; a_d_we = 1'b1; a_d_be = 4'hF; a_d_addr = 32'h20; a_d_wdata = 32'hA5A5A5A5;
         for (int n = 1; n <= 20 && !seen; n++) begin
            @(posedge clk); #1;
            if (a7_d_ack) seen = 1'b1;
         end
         chk("abort_prewrite_ack", {31'd0, seen}, 32'd1);
         a_d_req = 1'b0;
         @(posedge clk); #1;
         a_d_req = 1'b1; a_d_wdata = 32'h0BADF00D;
         @(posedge clk); #1;
         @(posedge clk); #1;
         a_reset = 1'b1; a_d_req = 1'b0;
         @(posedge clk); #1;
         a_reset = 1'b0;
         ack_after = 1'b0;
         for (int n = 1; n <= 15; n++) begin
            @(posedge clk); #1;
            if (a7_d_ack) ack_after = 1'b1;
         end
         chk("abort_no_ack", {31'd0, ack_after}, 32'd0);
         seen = 1'b0;
         a_d_req = 1'b1; a_d_we = 1'b0;
         for (int n = 1; n <= 20 && !seen; n++) begin
            @(posedge clk); #1;
            if (a7_d_ack) begin
               seen = 1'b1;
               chk("abort_lat", 32'(n), 32'd9);
               chk("abort_old_value", a7_d_rdata, 32'hA5A5A5A5);
            end
         end
         chk("abort_read_ack", {31'd0, seen}, 32'd1);
         a_d_req = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
